// File: rtl/i2s_sample_fifo.sv
// Stereo-word FWFT FIFO behind the I2S deserializer; drops and flags words when full.
// Optional drop counter enabled by defining I2S_SAMPLE_FIFO_DROP_CNT_EN.

package i2s_common_pkg;
   localparam int I2S_BITS = 16;
endpackage

module i2s_sample_fifo
   import i2s_common_pkg::*;
#(
   parameter int WORD_W = I2S_BITS * 2,
   parameter int DEPTH  = 8,
   parameter int LVL_W  = $clog2(DEPTH + 1)
) (
   input  logic              bck,
   input  logic              rst_n,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic [WORD_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LVL_W-1:0]  level,
   output logic              full,
   output logic              overflow,
`ifdef I2S_SAMPLE_FIFO_DROP_CNT_EN
   output logic [15:0]       drop_cnt,
`endif
   input  logic              overflow_clr
);

   localparam int PTR_W = $clog2(DEPTH);

   // Handshake: a word leaves when out_valid and out_ready are both 1 at a
   // rising bck edge. The input side has no ready; in_valid is a strobe that
   // is either stored or dropped in that same cycle.

   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [LVL_W-1:0]  r_level;
   logic              r_valid;
   logic              r_full;
   logic              r_overflow;

   logic              w_push;
   logic              w_pop;
   logic              w_drop;
   logic [LVL_W-1:0]  w_level_nxt;

   // A pop frees a slot in the same cycle, so a full FIFO can still accept.
   assign w_pop  = r_valid & out_ready;
   assign w_push = in_valid & (~r_full | w_pop);
   assign w_drop = in_valid & r_full & ~w_pop;

   always_comb begin
      w_level_nxt = r_level;
      case ({w_push, w_pop})
         2'b10:   w_level_nxt = r_level + LVL_W'(1);
         2'b01:   w_level_nxt = r_level - LVL_W'(1);
         default: w_level_nxt = r_level;
      endcase
   end

   // Storage is not reset; out_data is masked while empty instead.
   always_ff @(posedge bck) begin
      if (rst_n && w_push) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge bck) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_valid  <= 1'b0;
         r_full   <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_level <= w_level_nxt;
         r_valid <= (w_level_nxt != '0);
         r_full  <= (w_level_nxt == LVL_W'(DEPTH));
      end
   end

   // A fresh drop wins over a clear arriving in the same cycle.
   always_ff @(posedge bck) begin
      if (!rst_n) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (overflow_clr) begin
         r_overflow <= 1'b0;
      end
   end

`ifdef I2S_SAMPLE_FIFO_DROP_CNT_EN
   logic [15:0] r_drop_cnt;

   always_ff @(posedge bck) begin
      if (!rst_n) begin
         r_drop_cnt <= '0;
      end else if (overflow_clr) begin
         r_drop_cnt <= w_drop ? 16'd1 : 16'd0;
      end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
         r_drop_cnt <= r_drop_cnt + 16'd1;
      end
   end

   assign drop_cnt = r_drop_cnt;
`endif

   assign out_data  = r_valid ? r_mem[r_rd_ptr] : '0;
   assign out_valid = r_valid;
   assign level     = r_level;
   assign full      = r_full;
   assign overflow  = r_overflow;

endmodule
